// File: rtl/cmp3_arb_pkg.sv
// cmp3_arb_pkg: shared FSM type and default sizes for cmp3_share_arb
package cmp3_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CMP = 2'd1, RESP = 2'd2} state_t;
  localparam int DEF_NREQ = 4;
  localparam int DEF_W = 3;
  localparam int TXN_W = 16;
endpackage

// File: rtl/cmp3_core.sv
// cmp3_core: combinational W-bit unsigned magnitude comparator
module cmp3_core #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);
  assign eq = a == b;
  assign gt = a > b;
  assign lt = a < b;
endmodule

// File: rtl/cmp3_share_arb.sv
// cmp3_share_arb: round-robin sharing of one comparator among NREQ requesters
// Define CMP3_ARB_STATS_EN to add the 16-bit txn_count output.
module cmp3_share_arb
  import cmp3_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_flat,
  input  logic [NREQ*W-1:0] b_flat,
  output logic [NREQ-1:0]   ack,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              equals,
  output logic              greater,
  output logic              lesser,
`ifdef CMP3_ARB_STATS_EN
  output logic [TXN_W-1:0]  txn_count,
`endif
  output logic              busy
);
  state_t state, state_nx;
  logic [IDW-1:0] ptr, id, win;
  logic [W-1:0] a_q, b_q;
  logic eq, gt, lt;
  cmp3_core #(.W(W)) u_core (.a(a_q), .b(b_q), .eq(eq), .gt(gt), .lt(lt));
  // Scan downward so the requester closest to ptr (with wrap) wins.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NREQ]) win = IDW'((int'(ptr) + i) % NREQ);
  end
  always_comb state_nx = (state == IDLE) ? (|req ? CMP : IDLE) : (state == CMP) ? RESP : IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      id <= '0;
      a_q <= '0;
      b_q <= '0;
      ack <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      equals <= 1'b0;
      greater <= 1'b0;
      lesser <= 1'b0;
    end else begin
      ack <= '0;
      rsp_valid <= 1'b0;
      if (state == IDLE && |req) begin
        id <= win;
        a_q <= a_flat[int'(win)*W +: W];
        b_q <= b_flat[int'(win)*W +: W];
      end
      if (state == CMP) begin
        equals <= eq;
        greater <= gt;
        lesser <= lt;
        ack <= NREQ'(1) << id;
        rsp_valid <= 1'b1;
        rsp_id <= id;
      end
      if (state == RESP) ptr <= IDW'((int'(id) + 1) % NREQ);
    end
  end
`ifdef CMP3_ARB_STATS_EN
  always_ff @(posedge clk) txn_count <= rst ? '0 : txn_count + TXN_W'(rsp_valid);
`endif
endmodule

// File: tb/tb_cmp3_share_arb.sv
// tb_cmp3_share_arb: directed checks of grant order, flags, timing and reset
module tb_cmp3_share_arb;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [11:0] a_flat, b_flat;
  logic [3:0] ack;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic equals, greater, lesser, busy;
`ifdef CMP3_ARB_STATS_EN
  logic [15:0] txn_count;
`endif
  int checks = 0;
  int failures = 0;
  int cyc_ctr = 0;

  cmp3_share_arb dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .equals(equals), .greater(greater), .lesser(lesser),
`ifdef CMP3_ARB_STATS_EN
    .txn_count(txn_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr++;

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid, captures outputs, drops the served req,
  // then steps one more cycle so the DUT is back in IDLE.
  task automatic wait_rsp(output int lat, output int stamp, output logic [3:0] ack_o,
                          output logic [1:0] id_o, output logic [2:0] fl);
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    stamp = cyc_ctr;
    ack_o = ack;
    id_o = rsp_id;
    fl = {equals, greater, lesser};
    req = req & ~ack;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (ack !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b want=0000", ack); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", rsp_valid); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d want=0", rsp_id); end
    if ({equals, greater, lesser} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {equals, greater, lesser}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    a_flat[2:0] = 3'b010;
    b_flat[2:0] = 3'b110;
    req = 4'b0001;
    @(posedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
    if (ack !== 4'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_early_ack got=%b/%b want=0000/0", ack, rsp_valid); end
    @(posedge clk);
    #1;
    checks += 4;
    if (ack !== 4'b0001) begin failures++; $display("FAIL basic_ack got=%b want=0001", ack); end
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b want=1", rsp_valid); end
    if (rsp_id !== 2'd0) begin failures++; $display("FAIL basic_id got=%0d want=0", rsp_id); end
    if ({equals, greater, lesser} !== 3'b001) begin failures++; $display("FAIL basic_flags got=%b want=001", {equals, greater, lesser}); end
    req = 4'b0;
    @(posedge clk);
    #1;
    checks += 3;
    if (ack !== 4'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b/%b want=0000/0", ack, rsp_valid); end
    if ({equals, greater, lesser} !== 3'b001) begin failures++; $display("FAIL basic_hold got=%b want=001", {equals, greater, lesser}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_flags();
    int lat, st;
    logic [3:0] a_o;
    logic [1:0] id_o;
    logic [2:0] fl;
    a_flat[5:3] = 3'd6;
    b_flat[5:3] = 3'd2;
    req = 4'b0010;
    wait_rsp(lat, st, a_o, id_o, fl);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL gt_latency got=%0d want=2", lat); end
    if (id_o !== 2'd1 || a_o !== 4'b0010) begin failures++; $display("FAIL gt_id got=%0d/%b want=1/0010", id_o, a_o); end
    if (fl !== 3'b010) begin failures++; $display("FAIL gt_flags got=%b want=010", fl); end
    a_flat[8:6] = 3'd5;
    b_flat[8:6] = 3'd5;
    req = 4'b0100;
    wait_rsp(lat, st, a_o, id_o, fl);
    checks += 2;
    if (id_o !== 2'd2 || a_o !== 4'b0100) begin failures++; $display("FAIL eq_id got=%0d/%b want=2/0100", id_o, a_o); end
    if (fl !== 3'b100) begin failures++; $display("FAIL eq_flags got=%b want=100", fl); end
  endtask

  task automatic test_round_robin();
    int lat, st, prev;
    logic [3:0] a_o;
    logic [1:0] id_o;
    logic [2:0] fl;
    do_reset();
    prev = 0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(lat, st, a_o, id_o, fl);
      checks += 2;
      if (id_o !== 2'(i) || a_o !== 4'(1 << i)) begin failures++; $display("FAIL rr_order_%0d got=%0d/%b want=%0d/%b", i, id_o, a_o, i, 4'(1 << i)); end
      if (i > 0 && st - prev !== 3) begin failures++; $display("FAIL rr_spacing_%0d got=%0d want=3", i, st - prev); end
      else if (i == 0 && lat !== 2) begin failures++; $display("FAIL rr_first_latency got=%0d want=2", lat); end
      prev = st;
    end
  endtask

  task automatic test_wrap();
    int lat, st;
    logic [3:0] a_o;
    logic [1:0] id_o;
    logic [2:0] fl;
    req = 4'b0100;
    wait_rsp(lat, st, a_o, id_o, fl);
    req = 4'b1001;
    wait_rsp(lat, st, a_o, id_o, fl);
    checks++;
    if (id_o !== 2'd3 || a_o !== 4'b1000) begin failures++; $display("FAIL wrap_first got=%0d/%b want=3/1000", id_o, a_o); end
    wait_rsp(lat, st, a_o, id_o, fl);
    checks++;
    if (id_o !== 2'd0 || a_o !== 4'b0001) begin failures++; $display("FAIL wrap_second got=%0d/%b want=0/0001", id_o, a_o); end
  endtask

  task automatic test_reset_mid();
    int lat, st;
    logic [3:0] a_o;
    logic [1:0] id_o;
    logic [2:0] fl;
    a_flat[2:0] = 3'd1;
    b_flat[2:0] = 3'd4;
    req = 4'b0001;
    @(posedge clk);
    #1 rst = 1'b1;
    req = 4'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    checks += 3;
    if (ack !== 4'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_noack got=%b/%b want=0000/0", ack, rsp_valid); end
    if ({equals, greater, lesser} !== 3'b000) begin failures++; $display("FAIL mid_flags got=%b want=000", {equals, greater, lesser}); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 4'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_late_ack got=%b/%b want=0000/0", ack, rsp_valid); end
    req = 4'b0001;
    wait_rsp(lat, st, a_o, id_o, fl);
    checks += 2;
    if (lat !== 2 || a_o !== 4'b0001) begin failures++; $display("FAIL mid_fresh got=%0d/%b want=2/0001", lat, a_o); end
    if (fl !== 3'b001) begin failures++; $display("FAIL mid_fresh_flags got=%b want=001", fl); end
  endtask

  task automatic test_boundary();
    int lat, st;
    logic [3:0] a_o;
    logic [1:0] id_o;
    logic [2:0] fl;
    do_reset();
    a_flat[2:0] = 3'd7;
    b_flat[2:0] = 3'd0;
    req = 4'b0001;
    @(posedge clk);
    #1;
    a_flat[2:0] = 3'd0;
    b_flat[2:0] = 3'd7;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat !== 1 || {equals, greater, lesser} !== 3'b010) begin failures++; $display("FAIL bound_max_min got=%0d/%b want=1/010", lat, {equals, greater, lesser}); end
    req = 4'b0;
    @(posedge clk);
    #1 req = 4'b0001;
    wait_rsp(lat, st, a_o, id_o, fl);
    checks++;
    if (fl !== 3'b001) begin failures++; $display("FAIL bound_min_max got=%b want=001", fl); end
`ifdef CMP3_ARB_STATS_EN
    checks++;
    if (txn_count !== 16'd2) begin failures++; $display("FAIL txn_count got=%0d want=2", txn_count); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a_flat = '0;
    b_flat = '0;
    test_reset();
    test_basic();
    test_flags();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
